// File: rtl/dtc_mon_capture.sv
// Trigger-centred snapshot recorder for the selected DTC monitor word.
// Samples stream into a DEPTH-entry ring; readback is relative to the first kept sample.
module dtc_mon_capture #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  dcsclk,
  input  logic                  dcs_rst_n,
  input  logic [15:0]           dtc_deser_dout,
  input  logic [5:0]            dtc_mon_sel,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [1:0]            trig_mode,
  input  logic [15:0]           trig_pattern,
  input  logic [15:0]           trig_mask,
  input  logic                  ext_trig,
  input  logic [DEPTH_LOG2-1:0] pre_trig,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [15:0]           rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sel_err,
  output logic [15:0]           wait_cnt
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] ONE = 1;

  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;

  state_t                state_reg, state_next;
  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, start_ptr_reg, pre_cnt_reg, post_cnt_reg;
  logic [DEPTH_LOG2-1:0] post_len, rd_idx;
  logic [5:0]            sel_reg, sel_cap_reg;
  logic                  sel_bad, pat_match, trig, wr_en;

  // Samples still to be written after the trigger so the capture totals DEPTH.
  assign post_len = {DEPTH_LOG2{1'b1}} - pre_trig;
  assign rd_idx   = start_ptr_reg + rd_addr;

  assign busy = (state_reg == PRE) || (state_reg == WAIT_TRIG) || (state_reg == POST);
  assign done = (state_reg == DONE);

  assign pat_match = ((dtc_deser_dout ^ trig_pattern) & trig_mask) == 16'h0000;
  assign sel_bad   = busy && (sel_reg != sel_cap_reg);
  // The arm, abort and select-error cycles leave the buffer untouched.
  assign wr_en     = busy && !arm && !abort && !sel_bad;

  always_comb begin
    trig = 1'b0;
    case (trig_mode)
      2'd0:    trig = 1'b1;
      2'd1:    trig = pat_match;
      2'd2:    trig = ext_trig;
      default: trig = pat_match || ext_trig;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    if (arm) begin
      state_next = (pre_trig != '0) ? PRE : WAIT_TRIG;
    end else if (abort || sel_bad) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        PRE:       if (pre_cnt_reg + ONE == pre_trig) state_next = WAIT_TRIG;
        WAIT_TRIG: if (trig) state_next = (post_len == '0) ? DONE : POST;
        POST:      if (post_cnt_reg == ONE) state_next = DONE;
        default:   state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge dcsclk or negedge dcs_rst_n) begin
    if (!dcs_rst_n) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      start_ptr_reg <= '0;
      pre_cnt_reg   <= '0;
      post_cnt_reg  <= '0;
      sel_reg       <= '0;
      sel_cap_reg   <= '0;
      sel_err       <= 1'b0;
      wait_cnt      <= 16'h0000;
    end else begin
      state_reg <= state_next;
      sel_reg   <= dtc_mon_sel;
      if (arm) begin
        wr_ptr_reg  <= '0;
        pre_cnt_reg <= '0;
        wait_cnt    <= 16'h0000;
        sel_err     <= 1'b0;
        sel_cap_reg <= dtc_mon_sel;
      end else begin
        if (sel_bad) sel_err <= 1'b1;
        if (wr_en) wr_ptr_reg <= wr_ptr_reg + ONE;
        if (wr_en && state_reg == PRE) pre_cnt_reg <= pre_cnt_reg + ONE;
        if (wr_en && state_reg == WAIT_TRIG) begin
          if (trig) begin
            start_ptr_reg <= wr_ptr_reg - pre_trig;
            post_cnt_reg  <= post_len;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        if (wr_en && state_reg == POST) post_cnt_reg <= post_cnt_reg - ONE;
      end
    end
  end

  always_ff @(posedge dcsclk) begin
    if (wr_en) mem[wr_ptr_reg] <= dtc_deser_dout;
  end

  // Read-before-write: a same-address collision returns the previous contents.
  always_ff @(posedge dcsclk or negedge dcs_rst_n) begin
    if (!dcs_rst_n) rd_data <= 16'h0000;
    else            rd_data <= mem[rd_idx];
  end

endmodule
